apb_mem_slave: RTL and testbench

APB completer downstream of the APB master bridge: one instance sits behind each of the bridge's select lines (PSEL1 / PSEL2). It holds a byte-wide register memory and serves bridge transfers with a programmable number of wait states. It drives PREADY, PRDATA and PSLVERR back to the bridge.

---
 rtl/apb_mem_slave.sv | 103 ++++++++++
 tb/tb_apb_mem_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB completer with byte-wide register memory and programmable wait states
// Optional out-of-range error response enabled by defining APB_MEM_SLAVE_ERR_EN.
module apb_mem_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       i_pclk,
    input  logic       i_preset,
    input  logic       i_psel,
    input  logic       i_penable,
    input  logic       i_pwrite,
    input  logic [8:0] i_paddr,
    input  logic [7:0] i_pwdata,
    output logic       o_pready,
    output logic [7:0] o_prdata,
    output logic       o_pslverr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_addr_q;
    logic            r_wr_q;
    logic [7:0]      r_wd_q;
    logic            r_err;
    logic [7:0]      r_prdata;
    logic [7:0]      r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic            w_err;
    logic            w_unused;

    // Bit 8 is the bridge's select decode; upper offset bits only matter for the error check.
    assign w_idx    = i_paddr[AW-1:0];
    assign w_unused = ^i_paddr;

`ifdef APB_MEM_SLAVE_ERR_EN
    assign w_err = ({1'b0, i_paddr[7:0]} >= 9'(DEPTH));
`else
    assign w_err = 1'b0;
`endif

    assign o_pready  = (r_state == S_DONE) && i_psel && i_penable;
    assign o_pslverr = o_pready && r_err;
    assign o_prdata  = r_prdata;

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr_q <= '0;
            r_wr_q   <= 1'b0;
            r_wd_q   <= '0;
            r_err    <= 1'b0;
            r_prdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_psel && !i_penable) begin
                        r_addr_q <= w_idx;
                        r_wr_q   <= i_pwrite;
                        r_wd_q   <= i_pwdata;
                        r_err    <= w_err;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        if (w_err) begin
                            r_prdata <= '0;
                        end else if (!i_pwrite) begin
                            r_prdata <= r_mem[w_idx];
                        end
                        r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (!i_psel) begin
                        r_state <= S_IDLE;
                    end else if (i_penable) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Dropping PSEL here aborts: no commit, PRDATA untouched.
                    if (!i_psel) begin
                        r_state <= S_IDLE;
                    end else if (i_penable) begin
                        if (r_wr_q && !r_err) begin
                            r_mem[r_addr_q] <= r_wd_q;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - scoreboard bench for apb_mem_slave (three configurations on one bus)
module tb_apb_mem_slave;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       penable;
    logic       pwrite;
    logic [8:0] paddr;
    logic [7:0] pwdata;
    logic [2:0] rdy;
    logic [2:0] err;
    logic [7:0] rd [3];

    always #5 clk = ~clk;

    apb_mem_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .i_pclk(clk), .i_preset(rst), .i_psel(sel[0]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(rdy[0]), .o_prdata(rd[0]), .o_pslverr(err[0]));
    apb_mem_slave #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .i_pclk(clk), .i_preset(rst), .i_psel(sel[1]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(rdy[1]), .o_prdata(rd[1]), .o_pslverr(err[1]));
    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(1)) dut_c (
        .i_pclk(clk), .i_preset(rst), .i_psel(sel[2]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(rdy[2]), .o_prdata(rd[2]), .o_pslverr(err[2]));

    typedef struct {
        int         d;
        logic       is_rd;
        logic [7:0] data;
        logic       slverr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (|rdy)) begin
            if (q.size() == 0) begin
                chk("unexpected_pready", 32'(rdy), 32'd0);
            end else begin
                e = q.pop_front();
                chk("pready_dut", 32'(rdy), 32'(1) << e.d);
                chk("pslverr", 32'(err[e.d]), 32'(e.slverr));
                if (e.is_rd) chk("prdata", 32'(rd[e.d]), 32'(e.data));
            end
        end
    end

    // Entered and left at posedge+1; leaves the bus idle so the next call can set up back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [8:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err, input int exp_waits,
                        input logic scramble, input string name);
        int waits;
        bit done;
        q.push_back('{d, !wr, exp_rd, exp_err});
        sel = '0; sel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            paddr = ~a; pwdata = ~wd; pwrite = ~wr;
        end
        waits = 0;
        done  = 0;
        while (!done && waits <= 20) begin
            @(negedge clk);
            if (rdy[d]) done = 1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        chk({name, "_waits"}, 32'(waits), 32'(exp_waits));
        @(posedge clk); #1;
        sel = '0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        sel = '0; penable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_prdata", 32'(rd[d]), 32'd0);
            chk("reset_pready", 32'(rdy[d]), 32'd0);
            chk("reset_pslverr", 32'(err[d]), 32'd0);
        end

        // Access phase without setup must be ignored.
        sel = 3'b111; penable = 1'b1;
        @(negedge clk); chk("nosetup_pready", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("nosetup_pready2", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        idle(1);

        xfer(0, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 2, 1'b0, "rd_reset_00");
        xfer(0, 1'b0, 9'h0FF, 8'h00, 8'h00, 1'b0, 2, 1'b0, "rd_reset_ff");
        xfer(0, 1'b1, 9'h012, 8'hA5, 8'h00, 1'b0, 2, 1'b0, "wr_a5");
        xfer(0, 1'b0, 9'h012, 8'h00, 8'hA5, 1'b0, 2, 1'b0, "rd_a5");
        idle(1);

        xfer(1, 1'b1, 9'h040, 8'h3C, 8'h00, 1'b0, 0, 1'b0, "wr_3c_zw");
        xfer(1, 1'b0, 9'h040, 8'h00, 8'h3C, 1'b0, 0, 1'b0, "rd_3c_zw");
        idle(1);

        // Abort: PSEL dropped in the first WAIT cycle.
        sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'hFF;
        @(posedge clk); #1;
        sel = '0; penable = 1'b0;
        @(negedge clk); chk("abort_pready", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("abort_pready2", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 9'h020, 8'h00, 8'h00, 1'b0, 2, 1'b0, "rd_after_abort");

        // Access-phase address/data/direction changes are ignored.
        xfer(0, 1'b1, 9'h030, 8'h11, 8'h00, 1'b0, 2, 1'b1, "wr_scramble");
        xfer(0, 1'b0, 9'h030, 8'h00, 8'h11, 1'b0, 2, 1'b1, "rd_scramble");
        idle(1);

`ifdef APB_MEM_SLAVE_ERR_EN
        xfer(2, 1'b1, 9'h013, 8'h77, 8'h00, 1'b1, 1, 1'b0, "oor_wr");
        xfer(2, 1'b0, 9'h013, 8'h00, 8'h00, 1'b1, 1, 1'b0, "oor_rd");
        xfer(2, 1'b0, 9'h103, 8'h00, 8'h00, 1'b0, 1, 1'b0, "oor_rd_loc3");
`else
        xfer(2, 1'b1, 9'h013, 8'h77, 8'h00, 1'b0, 1, 1'b0, "wrap_wr");
        xfer(2, 1'b0, 9'h013, 8'h00, 8'h77, 1'b0, 1, 1'b0, "wrap_rd");
        xfer(2, 1'b0, 9'h103, 8'h00, 8'h77, 1'b0, 1, 1'b0, "wrap_rd_loc3");
`endif
        idle(1);

        // Reset in the middle of a write's wait states.
        sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 9'h001; pwdata = 8'h5A;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("rstmid_pready", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("rstmid_pready2", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        idle(1);
        xfer(0, 1'b0, 9'h001, 8'h00, 8'h00, 1'b0, 2, 1'b0, "rd_rstmid_01");
        xfer(0, 1'b0, 9'h012, 8'h00, 8'h00, 1'b0, 2, 1'b0, "rd_rstmid_12");
        idle(2);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
